// File: rtl/uart_bus_arbiter.sv
// Round-robin TX arbiter and RX drain sequencer in front of an 8-bit UART register file.
// Define UART_ARB_INIT_EN to compile the post-reset CTRL/baud-divisor boot sequence.
module uart_bus_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [7:0]  CTRL_INIT = 8'h03,
    parameter logic [15:0] BAUD_DIV  = 16'd434
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic                   rx_valid,
    output logic [7:0]             rx_data,
    input  logic                   rx_ready,
    output logic                   uart_cs,
    output logic                   uart_read,
    output logic                   uart_write,
    output logic [2:0]             uart_addr,
    output logic [7:0]             uart_wdata,
    input  logic [7:0]             uart_rdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_STATUS = 3'd1;
`ifdef UART_ARB_INIT_EN
    localparam logic [2:0] ADDR_CTRL   = 3'd2;
    localparam logic [2:0] ADDR_BAUD_L = 3'd3;
    localparam logic [2:0] ADDR_BAUD_H = 3'd4;
`endif

    typedef enum logic [2:0] {
        START,
`ifdef UART_ARB_INIT_EN
        INIT_CTRL,
        INIT_BL,
        INIT_BH,
`endif
        POLL,
        TX_WR,
        RX_RD
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [IW-1:0]   last_grant_reg;
    logic [IW-1:0]   winner;
    logic [7:0]      tx_byte_reg;
    logic            rx_valid_reg;
    logic [7:0]      rx_data_reg;
    logic            grant;
    logic            tx_ready_bit;
    logic            rx_ready_bit;
    int              scan_idx;
    logic [7:0]      req_byte [NUM_REQ];

    assign tx_ready_bit = uart_rdata[0];
    assign rx_ready_bit = uart_rdata[1];
    assign rx_valid     = rx_valid_reg;
    assign rx_data      = rx_data_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req_byte
            assign req_byte[gi] = req_data[8*gi +: 8];
        end
    endgenerate

    // Scan downward so the nearest valid index after last_grant is the last one written.
    always_comb begin
        winner   = '0;
        scan_idx = 0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            scan_idx = (int'(last_grant_reg) + k) % NUM_REQ;
            if (req_valid[IW'(scan_idx)]) begin
                winner = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        uart_cs    = 1'b0;
        uart_read  = 1'b0;
        uart_write = 1'b0;
        uart_addr  = 3'd0;
        uart_wdata = 8'h00;
        req_ready  = '0;
        grant      = 1'b0;
        case (state_reg)
            START: begin
`ifdef UART_ARB_INIT_EN
                state_next = INIT_CTRL;
`else
                state_next = POLL;
`endif
            end
`ifdef UART_ARB_INIT_EN
            INIT_CTRL: begin
                uart_cs    = 1'b1;
                uart_write = 1'b1;
                uart_addr  = ADDR_CTRL;
                uart_wdata = CTRL_INIT;
                state_next = INIT_BL;
            end
            INIT_BL: begin
                uart_cs    = 1'b1;
                uart_write = 1'b1;
                uart_addr  = ADDR_BAUD_L;
                uart_wdata = BAUD_DIV[7:0];
                state_next = INIT_BH;
            end
            INIT_BH: begin
                uart_cs    = 1'b1;
                uart_write = 1'b1;
                uart_addr  = ADDR_BAUD_H;
                uart_wdata = BAUD_DIV[15:8];
                state_next = POLL;
            end
`endif
            POLL: begin
                uart_cs   = 1'b1;
                uart_read = 1'b1;
                uart_addr = ADDR_STATUS;
                // A full holding register blocks RX even if the consumer is taking it this cycle.
                if (rx_ready_bit && !rx_valid_reg) begin
                    state_next = RX_RD;
                end else if (tx_ready_bit && (|req_valid)) begin
                    grant             = 1'b1;
                    req_ready[winner] = 1'b1;
                    state_next        = TX_WR;
                end
            end
            TX_WR: begin
                uart_cs    = 1'b1;
                uart_write = 1'b1;
                uart_addr  = ADDR_DATA;
                uart_wdata = tx_byte_reg;
                state_next = POLL;
            end
            RX_RD: begin
                uart_cs    = 1'b1;
                uart_read  = 1'b1;
                uart_addr  = ADDR_DATA;
                state_next = POLL;
            end
            default: state_next = START;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= START;
            last_grant_reg <= IW'(NUM_REQ - 1);
            tx_byte_reg    <= 8'h00;
            rx_valid_reg   <= 1'b0;
            rx_data_reg    <= 8'h00;
        end else begin
            state_reg <= state_next;
            if (grant) begin
                tx_byte_reg    <= req_byte[winner];
                last_grant_reg <= winner;
            end
            if (state_reg == RX_RD) begin
                rx_valid_reg <= 1'b1;
                rx_data_reg  <= uart_rdata;
            end else if (rx_valid_reg && rx_ready) begin
                rx_valid_reg <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_bus_arbiter.sv
// Randomized bench for uart_bus_arbiter: a transaction-level model predicts every bus cycle.
// Honours UART_ARB_INIT_EN the same way as the design.
module tb_uart_bus_arbiter;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [8*N-1:0]  req_data = '0;
    logic [N-1:0]    req_ready;
    logic            rx_valid;
    logic [7:0]      rx_data;
    logic            rx_ready = 1'b0;
    logic            uart_cs;
    logic            uart_read;
    logic            uart_write;
    logic [2:0]      uart_addr;
    logic [7:0]      uart_wdata;
    logic [7:0]      uart_rdata;
    logic [7:0]      status = 8'h00;
    logic [7:0]      rx_byte = 8'h00;

    uart_bus_arbiter #(
        .NUM_REQ   (N),
        .CTRL_INIT (8'h03),
        .BAUD_DIV  (16'd434)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rx_valid   (rx_valid),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .uart_cs    (uart_cs),
        .uart_read  (uart_read),
        .uart_write (uart_write),
        .uart_addr  (uart_addr),
        .uart_wdata (uart_wdata),
        .uart_rdata (uart_rdata)
    );

    always #5 clk = ~clk;

    // Simple UART register file: STATUS and DATA reads are combinational from the address.
    always_comb begin
        uart_rdata = 8'h00;
        if (uart_addr == 3'd1) uart_rdata = status;
        else if (uart_addr == 3'd0) uart_rdata = rx_byte;
    end

    int checks = 0;
    int errors = 0;

    // Model state: what the bus must do next, independent of how the design encodes it.
    bit         m_started;
    int         m_boot;
    int         m_tx;
    int         m_tx_src;
    bit         m_rxpend;
    bit         m_rxv;
    logic [7:0] m_rxd;
    int         m_last;
    bit         v [N];
    logic [7:0] d [N];
    bit         taken [N];
    logic [N-1:0] last_rr;
    logic [7:0] boot_vals [3];

    function automatic bit roll(input int p);
        return int'($urandom_range(99)) < p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_started = 1'b0;
`ifdef UART_ARB_INIT_EN
        m_boot = 0;
`else
        m_boot = 3;
`endif
        m_tx     = -1;
        m_tx_src = 0;
        m_rxpend = 1'b0;
        m_rxv    = 1'b0;
        m_rxd    = 8'h00;
        m_last   = N - 1;
        for (int i = 0; i < N; i++) begin
            v[i]     = 1'b0;
            taken[i] = 1'b0;
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_strobes"}, 32'({uart_cs, uart_read, uart_write}), 32'd0);
        chk({tag, "_addr"}, 32'(uart_addr), 32'd0);
        chk({tag, "_wdata"}, 32'(uart_wdata), 32'd0);
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_rx_valid"}, 32'(rx_valid), 32'd0);
        chk({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_zero("start");
        @(posedge clk);
        m_started = 1'b1;
    endtask

    // One clock cycle: drive inputs, predict the bus cycle, compare, advance the model.
    task automatic step(input int ptx, input int prx, input int pval, input int prdy);
        bit         e_cs, e_rd, e_wr;
        logic [2:0] e_addr;
        logic [7:0] e_wdata;
        logic [N-1:0] e_rr;
        int         nx_tx, nx_boot, nx_last, w;
        bit         nx_rxpend, nx_rxv;
        logic [7:0] nx_rxd;
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (taken[i]) begin
                v[i]     = 1'b0;
                taken[i] = 1'b0;
            end else if (!v[i]) begin
                if (roll(pval)) begin
                    v[i] = 1'b1;
                    d[i] = 8'($urandom);
                end
            end else if (roll(4)) begin
                v[i] = 1'b0;
            end
            req_valid[i]       = v[i];
            req_data[8*i +: 8] = d[i];
        end
        status   = {6'b0, roll(prx), roll(ptx)};
        rx_byte  = 8'($urandom);
        rx_ready = roll(prdy);
        #1;
        e_cs = 0; e_rd = 0; e_wr = 0; e_addr = 3'd0; e_wdata = 8'h00; e_rr = '0;
        nx_tx = -1; nx_boot = m_boot; nx_last = m_last; nx_rxpend = 1'b0;
        nx_rxv = m_rxv; nx_rxd = m_rxd;
        if (!m_started) begin
            // still in the post-reset idle cycle
        end else if (m_boot < 3) begin
            e_cs = 1; e_wr = 1; e_addr = 3'(2 + m_boot); e_wdata = boot_vals[m_boot];
            nx_boot = m_boot + 1;
            $display("BOOT write addr=%0d data=%02h", e_addr, e_wdata);
        end else if (m_tx >= 0) begin
            e_cs = 1; e_wr = 1; e_addr = 3'd0; e_wdata = 8'(m_tx);
            $display("TX   req%0d byte=%02h", m_tx_src, e_wdata);
        end else if (m_rxpend) begin
            e_cs = 1; e_rd = 1; e_addr = 3'd0;
            nx_rxv = 1'b1; nx_rxd = rx_byte;
            $display("RX   captured byte=%02h", rx_byte);
        end else begin
            e_cs = 1; e_rd = 1; e_addr = 3'd1;
            if (status[1] && !m_rxv) begin
                nx_rxpend = 1'b1;
            end else if (status[0]) begin
                w = -1;
                for (int k = 1; k <= N; k++) begin
                    if (w < 0 && v[(m_last + k) % N]) w = (m_last + k) % N;
                end
                if (w >= 0) begin
                    e_rr[w]  = 1'b1;
                    nx_tx    = int'(d[w]);
                    nx_last  = w;
                    taken[w] = 1'b1;
                    m_tx_src = w;
                end
            end
        end
        if (m_rxv && rx_ready) begin
            nx_rxv = 1'b0;
            $display("RX   delivered byte=%02h", m_rxd);
        end
        last_rr = req_ready;
        chk("strobes", 32'({uart_cs, uart_read, uart_write}), 32'({e_cs, e_rd, e_wr}));
        chk("addr", 32'(uart_addr), 32'(e_addr));
        if (e_wr || !m_started) chk("wdata", 32'(uart_wdata), 32'(e_wdata));
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        chk("rx_valid", 32'(rx_valid), 32'(m_rxv));
        chk("rx_data", 32'(rx_data), 32'(m_rxd));
        @(posedge clk);
        m_started = 1'b1;
        m_boot    = nx_boot;
        m_tx      = nx_tx;
        m_last    = nx_last;
        m_rxpend  = nx_rxpend;
        m_rxv     = nx_rxv;
        m_rxd     = nx_rxd;
    endtask

    initial begin
        bit found;
        int boot_steps;
        boot_vals[0] = 8'h03;
        boot_vals[1] = 8'hB2;
        boot_vals[2] = 8'h01;
`ifdef UART_ARB_INIT_EN
        boot_steps = 3;
`else
        boot_steps = 0;
`endif
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_zero("in_reset");
        end
        release_reset();

        repeat (20)   step(0, 0, 0, 50);        // idle: STATUS read every cycle
        repeat (300)  step(100, 0, 100, 100);   // saturated round-robin
        repeat (60)   step(0, 0, 60, 50);       // TX backpressure
        repeat (100)  step(100, 100, 80, 0);    // RX held, consumer stalled
        repeat (2000) step(60, 40, 50, 60);     // mixed traffic

        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            step(100, 0, 100, 100);
            if (m_tx >= 0) found = 1'b1;
        end
        chk("reach_tx_wr", 32'(found), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("reset_in_tx_wr");
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            check_zero("held_reset");
        end
        release_reset();
        repeat (boot_steps) step(100, 0, 100, 100);
        step(100, 0, 100, 100);
        chk("first_grant_after_reset", 32'(last_rr), 32'd1);

        repeat (500) step(70, 50, 60, 50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_bus_arbiter.md
# uart_bus_arbiter

Sequencer and arbiter sitting between NUM_REQ byte-stream clients and the `uart` 8-bit register interface. Continuously polls the UART STATUS register, grants one TX requester round-robin whenever TX_READY is set, and drains received bytes into a one-entry RX holding register with a valid/ready output. An optional boot sequence programs the UART's CTRL and baud-divisor registers after reset, so no CPU is needed for console bring-up.

## Interface
- NUM_REQ, 2: number of TX requesters; legal range 2..8.
- CTRL_INIT, 8'h03: value written to UART CTRL by the boot sequence.
- BAUD_DIV, 16'd434: value written to BAUD_H:BAUD_L by the boot sequence.
- clk  in  1  the single clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester byte valid; must hold req_data stable until accepted.
- req_data  in  8*NUM_REQ  byte i at bits [8i+7:8i].
- req_ready  out  NUM_REQ  one-hot accept pulse; transfer occurs when valid&ready.
- rx_valid  out  1  RX holding register full.
- rx_data  out  8  received byte.
- rx_ready  in  1  consumer accepts rx_data.
- uart_cs, uart_read, uart_write  out  1  UART strobes.
- uart_addr  out  3  UART register address: DATA=0, STATUS=1, CTRL=2, BAUD_L=3, BAUD_H=4.
- uart_wdata  out  8  UART write data.
- uart_rdata  in  8  UART read data (combinational from uart_addr); STATUS bit0=TX_READY, bit1=RX_READY.

## Operation
- FSM states: START, INIT_CTRL, INIT_BL, INIT_BH, POLL, TX_WR, RX_RD.
- START: all uart_* outputs 0; req_ready 0. Next state is INIT_CTRL (macro defined) or POLL.
- INIT_CTRL/INIT_BL/INIT_BH: cs=1, write=1, addr=2/3/4, wdata=CTRL_INIT / BAUD_DIV[7:0] / BAUD_DIV[15:8]; one cycle each, in that order, then POLL.
- POLL: cs=1, read=1, addr=1. Decision is made from uart_rdata in the same cycle:
  - If RX_READY=1 and rx_valid=0, next state is RX_RD. RX has priority over TX.
  - Else, if TX_READY=1 and any req_valid is set: the winner is the first set index strictly after last_grant, scanning cyclically. req_ready[winner]=1 in this cycle; the block latches req_data[winner] and sets last_grant=winner. Next state is TX_WR.
  - Else, stay in POLL.
- TX_WR: cs=1, write=1, addr=0, wdata=latched byte; one cycle, then POLL.
- RX_RD: cs=1, read=1, addr=0. The block captures uart_rdata into rx_data and sets rx_valid; one cycle, then POLL.
- RX holding register: rx_valid clears on the clock edge where rx_valid&rx_ready. There is no same-cycle bypass: a POLL seeing rx_valid=1 never enters RX_RD, even if rx_ready=1.
- All uart_* strobes and req_ready are combinational decodes of state plus the POLL decision. In any state not listed as driving a strobe, that strobe is 0.

## Timing
- Reset values: state=START, last_grant=NUM_REQ-1 (requester 0 wins first), rx_valid=0, rx_data=8'h00, latched byte=8'h00. While in reset, all outputs are 0.
- TX byte: from accept (POLL cycle) to UART write (TX_WR) is 1 cycle. Minimum TX period is 2 cycles per byte.
- RX byte: rx_valid rises 2 cycles after the POLL that sees RX_READY.
- A reset asserted mid-sequence returns the block to START immediately. A latched but unwritten TX byte is discarded, since it was already handshaked and is lost. A boot sequence interrupted by reset restarts from INIT_CTRL.
- No requester valid and no RX data: the block stays in POLL indefinitely, issuing a STATUS read every cycle. STATUS reads have no side effects.
- A requester that drops req_valid before being granted is simply skipped. Grant never goes to a requester whose req_valid is 0.
- Each DATA read or write is exactly one cycle, so exactly one UART FIFO pop or push occurs per access.

## Configuration
- UART_ARB_INIT_EN defined: START→INIT_CTRL→INIT_BL→INIT_BH→POLL. The first POLL occurs 5 cycles after reset release.
- UART_ARB_INIT_EN undefined: the INIT states and their decode are not compiled. START→POLL, and the first POLL occurs 2 cycles after reset release. The UART keeps its own reset defaults.

## Test plan
- Boot (macro on): release reset → writes CTRL=0x03, BAUD_L=0xB2, BAUD_H=0x01 on consecutive cycles, then a STATUS read every cycle.
- Round-robin: NUM_REQ=2, both valid with bytes 0x41/0x42, TX_READY=1 → UART DATA writes 0x41, 0x42, 0x41, …, alternating, each with a one-cycle req_ready pulse to the matching requester.
- Backpressure: STATUS=0x00 with req_valid[0]=1 → no req_ready and no write. STATUS→0x01 → req_ready[0] in that cycle, and a DATA write of the byte the next cycle.
- RX priority/hold: STATUS=0x03, rx byte 0x5A, req_valid[1]=1 → DATA read first, rx_valid=1 with rx_data=0x5A, then the TX grant. With rx_ready=0 and STATUS still 0x03 → no further DATA reads.
- Reset mid-TX: assert rst_n low in TX_WR → no write strobe, and all outputs 0. After release, the first grant goes to requester 0.
